// File: rtl/event_capture_encoder.sv
// rtl/event_capture_encoder.sv - synchronised 8-line event capture with highest-first 3-bit code handshake
module event_capture_encoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    output logic [2:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [7:0] pending,
    output logic [7:0] overflow,
    input  logic       ovf_clr
);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] hist_q;
    logic [7:0] evt;
    logic [7:0] sel_mask;
    logic [7:0] clr_mask;
    logic [7:0] pending_d;
    logic [7:0] overflow_d;
    logic [2:0] sel_code;
    logic       load;

    // Stage 0 takes d; the last stage feeds the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Ascending scan so the highest set bit is the one left selected.
    always_comb begin
        sel_code = 3'd0;
        sel_mask = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                sel_code    = 3'(i);
                sel_mask    = 8'd0;
                sel_mask[i] = 1'b1;
            end
        end
    end

    assign load       = (~code_valid | code_ready) & (|pending);
    assign clr_mask   = load ? sel_mask : 8'd0;
    // A new event on a bit being loaded re-arms it rather than overflowing.
    assign pending_d  = (pending & ~clr_mask) | evt;
    assign overflow_d = (ovf_clr ? 8'd0 : overflow) | (evt & pending & ~clr_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code       <= 3'd0;
            code_valid <= 1'b0;
        end else if (load) begin
            code       <= sel_code;
            code_valid <= 1'b1;
        end else if (code_ready) begin
            code_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_event_capture_encoder.sv
// tb/tb_event_capture_encoder.sv - scoreboard bench for event_capture_encoder
module tb_event_capture_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] pending;
    logic [7:0] overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;
    int sb[$];

    event_capture_encoder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending    (pending),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] mask);
        d = mask;
        tick(2);
        d = 8'h00;
        tick(2);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick(1);
            n++;
        end
        tick(3);
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every accepted handshake must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && code_valid && code_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_code: got %0d expected none at %0t", code, $time);
            end else begin
                chk("code", 32'(code), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        d          = 8'h00;
        code_ready = 1'b1;
        ovf_clr    = 1'b0;
        #2;
        chk("reset_state", 32'({code_valid, code, pending, overflow}), 32'd0);
        tick(3);
        rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", 32'({code_valid, code, pending, overflow}), 32'd0);
        end
        tick(1);

        // 2: latency of a held level, one event only
        d = 8'h08;
        sb.push_back(3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lat_not_yet", 32'(code_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", 32'({code_valid, code}), 32'({1'b1, 3'd3}));
        @(negedge clk);
        chk("lat_accepted", 32'(code_valid), 32'd0);
        tick(10);
        d = 8'h00;
        drain("drain_lat");

        // 3: multi-hot burst delivered highest first
        d = 8'hA2;
        sb.push_back(7);
        sb.push_back(5);
        sb.push_back(1);
        @(posedge clk);
        #1 d = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("burst_pend0", 32'(pending), 32'h0A2);
        @(negedge clk);
        chk("burst_pend1", 32'(pending), 32'h022);
        @(negedge clk);
        chk("burst_pend2", 32'(pending), 32'h002);
        @(negedge clk);
        chk("burst_pend3", 32'(pending), 32'h000);
        drain("drain_burst");

        // 4: stall, merge, overflow, clear
        code_ready = 1'b0;
        sb.push_back(4);
        sb.push_back(4);
        pulse(8'h10);
        @(negedge clk);
        chk("stall_first", 32'({code_valid, code, pending}), 32'({1'b1, 3'd4, 8'h00}));
        @(posedge clk);
        #1 pulse(8'h10);
        @(negedge clk);
        chk("stall_second", 32'({code_valid, code, pending, overflow}), 32'({1'b1, 3'd4, 8'h10, 8'h00}));
        @(posedge clk);
        #1 pulse(8'h10);
        @(negedge clk);
        chk("stall_third", 32'({code_valid, code, pending, overflow}), 32'({1'b1, 3'd4, 8'h10, 8'h10}));
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 code_ready = 1'b1;
        drain("drain_stall");

        // 5: new event on line 6 coincides with its load
        d = 8'hC0;
        sb.push_back(7);
        sb.push_back(6);
        sb.push_back(6);
        @(posedge clk);
        #1 d = 8'h00;
        @(posedge clk);
        #1 d = 8'h40;
        @(posedge clk);
        #1 d = 8'h00;
        @(negedge clk);
        chk("coll_pend0", 32'(pending), 32'h0C0);
        @(negedge clk);
        chk("coll_pend1", 32'({code, pending}), 32'({3'd7, 8'h40}));
        @(negedge clk);
        chk("coll_pend2", 32'({code, pending, overflow}), 32'({3'd6, 8'h40, 8'h00}));
        @(negedge clk);
        chk("coll_pend3", 32'({code, pending, overflow}), 32'({3'd6, 8'h00, 8'h00}));
        drain("drain_coll");

        // 6: asynchronous reset mid-stream, then a level held through release
        code_ready = 1'b0;
        d = 8'h70;
        @(posedge clk);
        #1 d = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset", 32'({code_valid, code, pending}), 32'({1'b1, 3'd6, 8'h30}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({code_valid, code, pending, overflow}), 32'd0);
        d = 8'h01;
        code_ready = 1'b1;
        tick(2);
        sb.push_back(0);
        rst_n = 1'b1;
        tick(12);
        chk("post_reset_idle", 32'({code_valid, pending, overflow}), 32'd0);
        drain("drain_reset");
        d = 8'h00;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
